mem_access_ctrl: RTL and testbench

//   MAR/MDR holding stage and access sequencer sitting directly upstream of the
//   RAM. Latches address/data from the datapath bus, runs read/write cycles to the
//   RAM with a fixed wait-state count, and returns R (ready) to the control FSM.
//   It owns RAM_WE/RAM_RE; the RAM writes or reads only under its strobes.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 102 ++++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Bundles the datapath-side handshake and the RAM-side bus of the MAR/MDR
//   access controller.
//   Datapath -> ctrl : BUS_IN, LDMAR, LDMDR, MIO_EN, R_W
//   Ctrl -> datapath : R, MAR_OUT, MDR_OUT, BUSY_ERR
//   Ctrl -> RAM      : RAM_ADDR, RAM_WDATA, RAM_WE, RAM_RE
//   RAM -> ctrl      : RAM_RDATA
//   slave modport is the controller; master is its environment (datapath + RAM).
interface mem_access_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic [DATA_W-1:0] BUS_IN;
   logic              LDMAR;
   logic              LDMDR;
   logic              MIO_EN;
   logic              R_W;
   logic              R;
   logic [ADDR_W-1:0] MAR_OUT;
   logic [DATA_W-1:0] MDR_OUT;
   logic              BUSY_ERR;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [DATA_W-1:0] RAM_WDATA;
   logic              RAM_WE;
   logic              RAM_RE;
   logic [DATA_W-1:0] RAM_RDATA;

   modport slave (
      input  BUS_IN, LDMAR, LDMDR, MIO_EN, R_W, RAM_RDATA,
      output R, MAR_OUT, MDR_OUT, BUSY_ERR, RAM_ADDR, RAM_WDATA, RAM_WE, RAM_RE
   );

   modport master (
      output BUS_IN, LDMAR, LDMDR, MIO_EN, R_W, RAM_RDATA,
      input  R, MAR_OUT, MDR_OUT, BUSY_ERR, RAM_ADDR, RAM_WDATA, RAM_WE, RAM_RE
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MAR/MDR holding stage and RAM access sequencer. Latches address/data from
//   the datapath bus, runs a read or write to the RAM lasting WAIT_CYCLES+1
//   ACCESS cycles, then holds R high until the request (MIO_EN) drops.
//   Ports:
//     CLK   - rising-edge clock
//     RESET - synchronous active-high reset; also gates RAM_WE/RAM_RE at once
//     bus   - mem_access_ctrl_if.slave (datapath handshake + RAM bus)
module mem_access_ctrl #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   mem_access_ctrl_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rw_q, rw_d;
   logic              busy_err_q, busy_err_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         mar_q      <= '0;
         mdr_q      <= '0;
         cnt_q      <= '0;
         rw_q       <= 1'b0;
         busy_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mar_q      <= mar_d;
         mdr_q      <= mdr_d;
         cnt_q      <= cnt_d;
         rw_q       <= rw_d;
         busy_err_q <= busy_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mar_d      = mar_q;
      mdr_d      = mdr_q;
      cnt_d      = cnt_q;
      rw_d       = rw_q;
      busy_err_d = busy_err_q;

      case (state_q)
         IDLE: begin
            if (bus.LDMAR) mar_d = ADDR_W'(bus.BUS_IN);
            // A request in the same cycle wins over an MDR load; the load is
            // silently dropped rather than flagged.
            if (bus.LDMDR && !bus.MIO_EN) mdr_d = bus.BUS_IN;
            if (bus.MIO_EN) begin
               rw_d    = bus.R_W;
               cnt_d   = CNT_INIT;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!rw_q) mdr_d = bus.RAM_RDATA;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!bus.MIO_EN) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Loads while an access is in flight are rejected and remembered.
      if (state_q != IDLE && (bus.LDMAR || bus.LDMDR)) busy_err_d = 1'b1;
   end

   // Outputs decoded from state; RESET kills the RAM strobes in the same cycle.
   always_comb begin
      bus.R         = (state_q == DONE);
      bus.MAR_OUT   = mar_q;
      bus.MDR_OUT   = mdr_q;
      bus.BUSY_ERR  = busy_err_q;
      bus.RAM_ADDR  = mar_q;
      bus.RAM_WDATA = mdr_q;
      bus.RAM_RE    = !RESET && (state_q == ACCESS) && !rw_q;
      bus.RAM_WE    = !RESET && (state_q == ACCESS) && rw_q && (cnt_q == 4'd0);
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl. dut_a runs with WAIT_CYCLES=2,
//   dut_b with WAIT_CYCLES=0. Stimulus pushes expected RAM writes and R
//   episodes into queues; negedge monitors pop and compare.
//   "R rise at cycle n" means R is first seen high after rising edge n, so the
//   control FSM samples it at edge n+1 = e0+WAIT_CYCLES+2.
module tb_mem_access_ctrl;

   typedef struct {
      int unsigned cyc;
      logic [15:0] mar;
      logic [15:0] mdr;
      int unsigned re_cnt;
   } rexp_t;

   typedef struct {
      int unsigned cyc;
      logic [15:0] addr;
      logic [15:0] data;
   } wexp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   rexp_t ra_q[$];
   rexp_t rb_q[$];
   wexp_t we_q[$];

   mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) ia ();
   mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) ib ();

   mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2)) dut_a (
      .CLK(clk), .RESET(rst), .bus(ia.slave)
   );
   mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(0)) dut_b (
      .CLK(clk), .RESET(rst), .bus(ib.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for dut_a
   logic ra_prev = 1'b0;
   int unsigned re_cnt_a = 0;
   always @(negedge clk) begin
      wexp_t w;
      rexp_t r;
      if (ia.RAM_WE) begin
         if (we_q.size() == 0) chk("unexpected_we_a", ia.RAM_WE, 0);
         else begin
            w = we_q.pop_front();
            chk("we_cycle", cyc, w.cyc);
            chk("we_addr", ia.RAM_ADDR, w.addr);
            chk("we_data", ia.RAM_WDATA, w.data);
         end
      end
      if (ia.RAM_RE) re_cnt_a++;
      if (ia.R && !ra_prev) begin
         if (ra_q.size() == 0) chk("unexpected_r_a", ia.R, 0);
         else begin
            r = ra_q.pop_front();
            chk("r_cycle_a", cyc, r.cyc);
            chk("r_mar_a", ia.MAR_OUT, r.mar);
            chk("r_mdr_a", ia.MDR_OUT, r.mdr);
            chk("re_cycles_a", re_cnt_a, r.re_cnt);
         end
         re_cnt_a = 0;
      end
      if (rst) re_cnt_a = 0;
      ra_prev = ia.R;
   end

   // Monitor for dut_b (reads only)
   logic rb_prev = 1'b0;
   int unsigned re_cnt_b = 0;
   always @(negedge clk) begin
      rexp_t r;
      if (ib.RAM_WE) chk("unexpected_we_b", ib.RAM_WE, 0);
      if (ib.RAM_RE) re_cnt_b++;
      if (ib.R && !rb_prev) begin
         if (rb_q.size() == 0) chk("unexpected_r_b", ib.R, 0);
         else begin
            r = rb_q.pop_front();
            chk("r_cycle_b", cyc, r.cyc);
            chk("r_mar_b", ib.MAR_OUT, r.mar);
            chk("r_mdr_b", ib.MDR_OUT, r.mdr);
            chk("re_cycles_b", re_cnt_b, r.re_cnt);
         end
         re_cnt_b = 0;
      end
      if (rst) re_cnt_b = 0;
      rb_prev = ib.R;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // WAIT_CYCLES=2: WE at e0+2, R rise at e0+3, RE for 3 cycles on a read.
   task automatic start_a(input logic rw, input logic [15:0] mar, input logic [15:0] mdr);
      int unsigned e0;
      e0 = cyc + 1;
      ia.MIO_EN = 1'b1;
      ia.R_W    = rw;
      ra_q.push_back('{e0 + 3, mar, mdr, rw ? 0 : 3});
      if (rw) we_q.push_back('{e0 + 2, mar, mdr});
   endtask

   // WAIT_CYCLES=0 read: R rise at e0+1, RE for 1 cycle.
   task automatic start_b(input logic [15:0] mar, input logic [15:0] mdr);
      int unsigned e0;
      e0 = cyc + 1;
      ib.MIO_EN = 1'b1;
      ib.R_W    = 1'b0;
      rb_q.push_back('{e0 + 1, mar, mdr, 1});
   endtask

   task automatic wait_r(input bit b);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = b ? ib.R : ia.R;
      end
      chk(b ? "r_timeout_b" : "r_timeout_a", seen, 1);
   endtask

   task automatic finish_a();
      wait_r(1'b0);
      step();
      ia.MIO_EN = 1'b0;
      step();
   endtask

   initial begin
      // 1: reset with random inputs
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ia.BUS_IN = 16'($urandom); ia.LDMAR = 1'($urandom); ia.LDMDR = 1'($urandom);
         ia.MIO_EN = 1'($urandom);  ia.R_W = 1'($urandom);   ia.RAM_RDATA = 16'($urandom);
         ib.BUS_IN = 16'($urandom); ib.LDMAR = 1'($urandom); ib.LDMDR = 1'($urandom);
         ib.MIO_EN = 1'($urandom);  ib.R_W = 1'($urandom);   ib.RAM_RDATA = 16'($urandom);
         step();
      end
      @(negedge clk);
      chk("rst_mar", ia.MAR_OUT, 0);
      chk("rst_mdr", ia.MDR_OUT, 0);
      chk("rst_r", ia.R, 0);
      chk("rst_we", ia.RAM_WE, 0);
      chk("rst_re", ia.RAM_RE, 0);
      chk("rst_busy", ia.BUSY_ERR, 0);
      chk("rst_r_b", ib.R, 0);
      step();
      rst = 1'b0;
      ia.BUS_IN = '0; ia.LDMAR = 1'b0; ia.LDMDR = 1'b0; ia.MIO_EN = 1'b0; ia.R_W = 1'b0;
      ia.RAM_RDATA = '0;
      ib.BUS_IN = '0; ib.LDMAR = 1'b0; ib.LDMDR = 1'b0; ib.MIO_EN = 1'b0; ib.R_W = 1'b0;
      ib.RAM_RDATA = '0;
      step();

      // 2: write BEEF to 3000
      ia.LDMAR = 1'b1; ia.BUS_IN = 16'h3000;
      step();
      ia.LDMAR = 1'b0; ia.LDMDR = 1'b1; ia.BUS_IN = 16'hBEEF;
      step();
      ia.LDMDR = 1'b0;
      start_a(1'b1, 16'h3000, 16'hBEEF);
      finish_a();

      // 3: read 1234 from 3000
      ia.RAM_RDATA = 16'h1234;
      start_a(1'b0, 16'h3000, 16'h1234);
      finish_a();

      // 5: busy MDR load during a write, then two more accesses
      start_a(1'b1, 16'h3000, 16'h1234);
      step();
      ia.LDMDR = 1'b1; ia.BUS_IN = 16'hFFFF;
      step();
      ia.LDMDR = 1'b0;
      finish_a();
      @(negedge clk);
      chk("busy_set", ia.BUSY_ERR, 1);
      chk("busy_mdr_kept", ia.MDR_OUT, 16'h1234);
      ia.RAM_RDATA = 16'h5678;
      step();
      start_a(1'b0, 16'h3000, 16'h5678);
      finish_a();
      start_a(1'b1, 16'h3000, 16'h5678);
      finish_a();
      @(negedge clk);
      chk("busy_sticky", ia.BUSY_ERR, 1);
      step();

      // 4: WAIT_CYCLES=0 back-to-back reads, R held while MIO_EN stays high
      ib.LDMAR = 1'b1; ib.BUS_IN = 16'h0040;
      step();
      ib.LDMAR = 1'b0;
      ib.RAM_RDATA = 16'h0001;
      start_b(16'h0040, 16'h0001);
      wait_r(1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("r_hold_b", ib.R, 1);
         chk("re_hold_b", ib.RAM_RE, 0);
      end
      step();
      ib.MIO_EN = 1'b0;
      step();
      ib.RAM_RDATA = 16'h0002;
      start_b(16'h0040, 16'h0002);
      wait_r(1'b1);
      step();
      ib.MIO_EN = 1'b0;
      step();

      // 6: reset in the final ACCESS cycle of a write
      ia.MIO_EN = 1'b1; ia.R_W = 1'b1;
      step();
      step();
      step();
      rst = 1'b1;
      ia.MIO_EN = 1'b0;
      @(negedge clk);
      chk("midrst_we", ia.RAM_WE, 0);
      chk("midrst_re", ia.RAM_RE, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_r", ia.R, 0);
      chk("midrst_busy", ia.BUSY_ERR, 0);
      chk("midrst_mar", ia.MAR_OUT, 0);
      for (int i = 0; i < 5; i++) step();

      chk("we_queue_empty", we_q.size(), 0);
      chk("ra_queue_empty", ra_q.size(), 0);
      chk("rb_queue_empty", rb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
